mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between the instruction-fetch path (PC) and the

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/mem_port_arbiter_timer.sv | 29 ++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM states, requester
// identities and the round-robin pick used when both requesters contend.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int WAIT_CNT_W = 8;

    // Contention goes to whoever did not win last; a lone requester always wins.
    function automatic owner_t pick_owner(input logic if_req, input logic d_req,
                                          input owner_t last_gnt);
        if (if_req && d_req)
            return (last_gnt == OWN_IF) ? OWN_D : OWN_IF;
        else if (d_req)
            return OWN_D;
        else
            return OWN_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Wait-state timer: counts mem_ready-low cycles of the current access and flags
// when the tolerated budget has been used up. Saturates instead of wrapping.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    import mem_port_arbiter_pkg::*;

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and the
// data path; one access in flight, wait-state handshake, timeout with bus error.
module mem_port_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);
    import mem_port_arbiter_pkg::*;

    arb_state_t        r_state;
    owner_t            r_last;
    owner_t            r_owner;
    logic              r_mem_req;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_valid;
    logic              r_d_valid;
    logic              r_bus_err;

    logic   w_grant;
    logic   w_wait_en;
    logic   w_expired;
    logic   w_finish;
    owner_t w_pick;

    assign w_grant   = (r_state == ST_IDLE) && (if_req || d_req);
    assign w_pick    = pick_owner(if_req, d_req, r_last);
    assign w_wait_en = (r_state == ST_ACCESS) && !mem_ready;
    assign w_finish  = mem_ready || w_expired;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clock     (clock),
        .reset     (reset),
        .i_clr     (w_grant),
        .i_en      (w_wait_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last      <= OWN_IF;
            r_owner     <= OWN_IF;
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_bus_err  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner     <= w_pick;
                        r_last      <= w_pick;
                        r_mem_req   <= 1'b1;
                        r_mem_write <= (w_pick == OWN_D) && d_write;
                        r_mem_addr  <= (w_pick == OWN_D) ? d_addr : if_addr;
                        r_mem_wdata <= (w_pick == OWN_D) ? d_wdata : '0;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Ready wins over an expiring budget in the same cycle.
                    if (w_finish) begin
                        r_mem_req   <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_bus_err   <= !mem_ready;
                        r_state     <= ST_DONE;
                        if (r_owner == OWN_IF) begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            r_d_valid <= 1'b1;
                            if (!r_mem_write)
                                r_d_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign d_rdata   = r_d_rdata;
    assign d_valid   = r_d_valid;
    assign mem_req   = r_mem_req;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + randomized bench for mem_port_arbiter with a transaction-level model
// of the port (round-robin owner, access length from the memory's wait count).
module tb_mem_port_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = 15;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_req = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          mem_req;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          bus_err;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_err(bus_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    // transaction model state
    int          busy = 0;       // cycles the port remains occupied (access + completion)
    bit          was_idle = 1'b0;
    bit          m_last_d = 1'b0;
    bit          cur_d, cur_write, cur_to;
    logic [63:0] cur_addr, cur_wdata;
    logic [63:0] m_if_rdata = '0, m_d_rdata = '0;
    bit          grants[$];

    // memory agent
    int ag_waits = 0;
    int ag_left  = 0;
    bit ag_busy  = 1'b0;

    // observations and requester engine
    bit saw_if_v, saw_d_v, saw_berr;
    bit if_auto = 1'b0, d_auto = 1'b0;
    int if_pct = 0, d_pct = 0;
    int memreq_cycles = 0, memw_cycles = 0;

    function automatic logic [63:0] memf(input logic [63:0] a);
        if (a == 64'h40) return 64'h8B02_0041;
        return {~a[31:0], a[31:0] ^ 32'hA5A5_5A5A};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        // inputs still hold the values the DUT sampled at the edge just passed
        if (reset) begin
            busy = 0; m_last_d = 1'b0; m_if_rdata = '0; m_d_rdata = '0;
            chk1("rst_mem_write", mem_write, 1'b0);
            chk("rst_mem_addr", mem_addr, '0);
            chk("rst_mem_wdata", mem_wdata, '0);
        end else if (was_idle && (if_req || d_req)) begin
            cur_d     = (if_req && d_req) ? !m_last_d : d_req;
            m_last_d  = cur_d;
            grants.push_back(cur_d);
            cur_addr  = cur_d ? d_addr : if_addr;
            cur_write = cur_d && d_write;
            cur_wdata = d_wdata;
            cur_to    = (ag_waits > MW);
            busy      = (cur_to ? MW + 1 : ag_waits + 1) + 1;
        end
        saw_if_v = if_valid;
        saw_d_v  = d_valid;
        saw_berr = bus_err;
        chk1("dual_valid", if_valid && d_valid, 1'b0);
        was_idle = 1'b0;
        if (busy > 1) begin
            chk1("acc_mem_req", mem_req, 1'b1);
            chk("acc_mem_addr", mem_addr, cur_addr);
            chk1("acc_mem_write", mem_write, cur_write);
            if (cur_write) chk("acc_mem_wdata", mem_wdata, cur_wdata);
            chk1("acc_valids", if_valid || d_valid, 1'b0);
            chk1("acc_bus_err", bus_err, 1'b0);
            busy--;
        end else if (busy == 1) begin
            if (!cur_write) begin
                if (cur_d) m_d_rdata  = cur_to ? 64'h0 : memf(cur_addr);
                else       m_if_rdata = cur_to ? 64'h0 : memf(cur_addr);
            end
            chk1("done_mem_req", mem_req, 1'b0);
            chk1("done_if_valid", if_valid, !cur_d);
            chk1("done_d_valid", d_valid, cur_d);
            chk1("done_bus_err", bus_err, cur_to);
            busy = 0;
        end else begin
            chk1("idle_mem_req", mem_req, 1'b0);
            chk1("idle_valids", if_valid || d_valid, 1'b0);
            chk1("idle_bus_err", bus_err, 1'b0);
            was_idle = 1'b1;
        end
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
        if (mem_req) memreq_cycles++;
        if (mem_write) memw_cycles++;
        // memory: ready after ag_waits stall cycles; ready is noise while idle
        if (mem_req) begin
            if (!ag_busy) begin ag_busy = 1'b1; ag_left = ag_waits; end
            if (ag_left == 0) begin
                mem_ready = 1'b1; mem_rdata = memf(mem_addr);
            end else begin
                mem_ready = 1'b0; mem_rdata = {$urandom, $urandom}; ag_left--;
            end
        end else begin
            ag_busy = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = {$urandom, $urandom};
        end
        // requesters drop on completion, optionally re-request at random
        if (saw_if_v) if_req = 1'b0;
        else if (!if_req && if_auto && $urandom_range(1, 100) <= if_pct) begin
            if_req = 1'b1; if_addr = {$urandom, $urandom};
        end
        if (saw_d_v) d_req = 1'b0;
        else if (!d_req && d_auto && $urandom_range(1, 100) <= d_pct) begin
            d_req = 1'b1; d_addr = {$urandom, $urandom};
            d_wdata = {$urandom, $urandom}; d_write = 1'($urandom_range(0, 1));
        end
    endtask

    // waits for the owner's valid, then steps into the following idle cycle
    task automatic wait_valid(input bit is_d, output int cyc, output bit berr);
        bit got;
        got = 1'b0; cyc = 1; berr = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            tick();
            cyc++;
            got  = is_d ? saw_d_v : saw_if_v;
            berr = saw_berr;
        end
        chk1(is_d ? "wait_d_valid" : "wait_if_valid", got, 1'b1);
        tick();
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (if_req || d_req || busy != 0); k++) tick();
        chk1("drain_done", if_req || d_req || (busy != 0), 1'b0);
        tick();
    endtask

    initial begin
        int  cyc;
        bit  berr;
        int  g0;

        // reset state
        tick(); tick();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_valids", if_valid || d_valid, 1'b0);
        chk("rst_if_rdata", if_rdata, '0);
        reset = 1'b0;

        // 1: fetch, zero wait states
        ag_waits = 0; if_addr = 64'h40; if_req = 1'b1;
        wait_valid(1'b0, cyc, berr);
        chk("t1_latency", 64'(cyc), 64'd3);
        chk("t1_if_rdata", if_rdata, 64'h8B02_0041);
        chk1("t1_bus_err", berr, 1'b0);

        // 2: store, two wait states
        ag_waits = 2; memw_cycles = 0;
        d_addr = 64'h10; d_wdata = 64'hDEAD; d_write = 1'b1; d_req = 1'b1;
        wait_valid(1'b1, cyc, berr);
        chk("t2_mem_write_cycles", 64'(memw_cycles), 64'd3);
        chk("t2_d_rdata", d_rdata, 64'h0);
        d_write = 1'b0;

        // 3: both held after reset -> D, IF, D, IF
        reset = 1'b1; tick(); reset = 1'b0;
        grants.delete(); ag_waits = 0;
        if_addr = 64'h100; if_req = 1'b1;
        d_addr = 64'h200; d_req = 1'b1;
        if_auto = 1'b1; d_auto = 1'b1; if_pct = 100; d_pct = 100;
        for (int k = 0; k < 40 && grants.size() < 4; k++) tick();
        if_auto = 1'b0; d_auto = 1'b0;
        chk("t3_grant_count", 64'(grants.size() >= 4), 64'd1);
        if (grants.size() >= 4) begin
            chk1("t3_grant0", grants[0], 1'b1);
            chk1("t3_grant1", grants[1], 1'b0);
            chk1("t3_grant2", grants[2], 1'b1);
            chk1("t3_grant3", grants[3], 1'b0);
        end
        drain();

        // 4: load, then a load that never gets ready, then a normal load
        ag_waits = 0; d_write = 1'b0; d_addr = 64'h20; d_req = 1'b1;
        wait_valid(1'b1, cyc, berr);
        chk("t4_pre_d_rdata", d_rdata, memf(64'h20));
        ag_waits = 999; memreq_cycles = 0; d_addr = 64'h88; d_req = 1'b1;
        wait_valid(1'b1, cyc, berr);
        chk("t4_mem_req_cycles", 64'(memreq_cycles), 64'd16);
        chk1("t4_bus_err", berr, 1'b1);
        chk("t4_d_rdata", d_rdata, 64'h0);
        ag_waits = 1; d_addr = 64'h30; d_req = 1'b1;
        wait_valid(1'b1, cyc, berr);
        chk1("t4_after_bus_err", berr, 1'b0);
        chk("t4_after_d_rdata", d_rdata, memf(64'h30));

        // 5: reset in the second cycle of an access
        ag_waits = 999; d_addr = 64'h50; d_req = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk1("t5_mem_req", mem_req, 1'b0);
        chk1("t5_no_valid", saw_d_v, 1'b0);
        reset = 1'b0; ag_waits = 0;
        wait_valid(1'b1, cyc, berr);
        chk("t5_d_rdata", d_rdata, memf(64'h50));

        // 6: request dropped and address changed mid-access
        ag_waits = 3; d_addr = 64'h60; d_req = 1'b1;
        tick(); tick();
        d_req = 1'b0; d_addr = 64'h999;
        tick();
        chk("t6_mem_addr", mem_addr, 64'h60);
        g0 = 0;
        for (int k = 0; k < 20 && !g0; k++) begin tick(); g0 = int'(saw_d_v); end
        chk("t6_d_valid", 64'(g0), 64'd1);
        chk("t6_d_rdata", d_rdata, memf(64'h60));
        tick();

        // random traffic with random wait states, including timeout boundaries
        if_auto = 1'b1; d_auto = 1'b1; if_pct = 40; d_pct = 30;
        for (int k = 0; k < 600; k++) begin
            if (busy == 0 && !mem_req)
                ag_waits = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20))
                                                        : int'($urandom_range(0, 3));
            tick();
        end
        if_auto = 1'b0; d_auto = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
